// File: rtl/switch_ctrl.sv
// ============================================================================
// Module      : switch_ctrl
// Description : MMIO switch input controller: synchronise, debounce, latch
//               edge events (W1C) and raise a maskable level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_ctrl #(
    parameter int          WIDTH       = 24,
    parameter logic [31:0] BASE_ADDR   = 32'hFFFFF070,
    parameter int          TICK_DIV    = 50000,
    parameter int          DEB_SAMPLES = 4,
    parameter int          EDGE_MODE   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [31:0]      wdata,
    input  logic [WIDTH-1:0] sw,
    output logic [31:0]      rdata,
    output logic             irq
);

    localparam int                 c_cnt_w      = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_max    = c_cnt_w'(TICK_DIV - 1);
    localparam logic [31:0]        c_addr_data  = BASE_ADDR;
    localparam logic [31:0]        c_addr_raw   = BASE_ADDR + 32'h4;
    localparam logic [31:0]        c_addr_edge  = BASE_ADDR + 32'h8;
    localparam logic [31:0]        c_addr_irqen = BASE_ADDR + 32'hC;

    logic [WIDTH-1:0]       r_s1_q, w_s1_d;
    logic [WIDTH-1:0]       r_s2_q, w_s2_d;
    logic [c_cnt_w-1:0]     r_cnt_q, w_cnt_d;
    logic                   w_tick;
    logic [DEB_SAMPLES-1:0] r_hist_q [WIDTH];
    logic [DEB_SAMPLES-1:0] w_hist_d [WIDTH];
    logic [WIDTH-1:0]       r_stable_q, w_stable_d;
    logic [WIDTH-1:0]       r_stable_prev_q, w_stable_prev_d;
    logic [WIDTH-1:0]       r_edge_q, w_edge_d;
    logic [WIDTH-1:0]       r_irq_en_q, w_irq_en_d;
    logic [31:0]            r_rdata_q, w_rdata_d;
    logic                   r_irq_q, w_irq_d;

    logic [WIDTH-1:0]       w_rise, w_fall, w_edge_set, w_edge_clr;
    logic                   w_wr_edge, w_wr_irqen;
    logic [31:0]            w_rd_reg;
    logic                   w_rd_hit;

    generate
        if (WIDTH < 32) begin : g_wdata_pad
            logic w_unused_wdata;
            assign w_unused_wdata = ^wdata[31:WIDTH];
        end
    endgenerate

    assign w_tick = (r_cnt_q == c_cnt_max);

    always_comb begin
        w_s1_d          = sw;
        w_s2_d          = r_s1_q;
        w_cnt_d         = w_tick ? '0 : r_cnt_q + c_cnt_w'(1);
        w_stable_prev_d = r_stable_q;
        w_stable_d      = r_stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            w_hist_d[i] = r_hist_q[i];
            if (w_tick) begin
                w_hist_d[i] = {r_hist_q[i][DEB_SAMPLES-2:0], r_s2_q[i]};
                if (&w_hist_d[i]) begin
                    w_stable_d[i] = 1'b1;
                end else if (~|w_hist_d[i]) begin
                    w_stable_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_rise = r_stable_q & ~r_stable_prev_q;
        w_fall = ~r_stable_q & r_stable_prev_q;
        if (EDGE_MODE == 0) begin
            w_edge_set = w_rise;
        end else if (EDGE_MODE == 1) begin
            w_edge_set = w_fall;
        end else begin
            w_edge_set = w_rise | w_fall;
        end

        w_wr_edge  = wr_en && (addr == c_addr_edge);
        w_wr_irqen = wr_en && (addr == c_addr_irqen);
        w_edge_clr = w_wr_edge ? wdata[WIDTH-1:0] : '0;
        // A new event in the same cycle as its clear must not be lost.
        w_edge_d   = (r_edge_q & ~w_edge_clr) | w_edge_set;
        w_irq_en_d = w_wr_irqen ? wdata[WIDTH-1:0] : r_irq_en_q;
        w_irq_d    = |(r_edge_q & r_irq_en_q);

        w_rd_reg = '0;
        w_rd_hit = 1'b1;
        case (addr)
            c_addr_data:  w_rd_reg[WIDTH-1:0] = r_stable_q;
            c_addr_raw:   w_rd_reg[WIDTH-1:0] = r_s2_q;
            c_addr_edge:  w_rd_reg[WIDTH-1:0] = r_edge_q;
            c_addr_irqen: w_rd_reg[WIDTH-1:0] = r_irq_en_q;
            default:      w_rd_hit = 1'b0;
        endcase
        w_rdata_d = (rd_en && w_rd_hit) ? w_rd_reg : r_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_q          <= '0;
            r_s2_q          <= '0;
            r_cnt_q         <= '0;
            r_stable_q      <= '0;
            r_stable_prev_q <= '0;
            r_edge_q        <= '0;
            r_irq_en_q      <= '0;
            r_rdata_q       <= '0;
            r_irq_q         <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_hist_q[i] <= '0;
            end
        end else begin
            r_s1_q          <= w_s1_d;
            r_s2_q          <= w_s2_d;
            r_cnt_q         <= w_cnt_d;
            r_stable_q      <= w_stable_d;
            r_stable_prev_q <= w_stable_prev_d;
            r_edge_q        <= w_edge_d;
            r_irq_en_q      <= w_irq_en_d;
            r_rdata_q       <= w_rdata_d;
            r_irq_q         <= w_irq_d;
            for (int i = 0; i < WIDTH; i++) begin
                r_hist_q[i] <= w_hist_d[i];
            end
        end
    end

    assign rdata = r_rdata_q;
    assign irq   = r_irq_q;

endmodule

`default_nettype wire

// File: tb/tb_switch_ctrl.sv
// ============================================================================
// Module      : tb_switch_ctrl
// Description : Directed bench for switch_ctrl (rising-edge and both-edge
//               instances driven from one shared bus).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_ctrl;

    localparam logic [31:0] c_base = 32'hFFFFF070;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        rd_en  = 1'b0;
    logic        wr_en  = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [7:0]  sw     = '0;
    logic [31:0] rdata0, rdata2;
    logic        irq0, irq2;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    logic [31:0] q_exp0 [$];
    logic [31:0] q_exp2 [$];
    string       q_tag  [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    switch_ctrl #(
        .WIDTH(8), .BASE_ADDR(c_base), .TICK_DIV(4), .DEB_SAMPLES(3), .EDGE_MODE(0)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wdata(wdata), .sw(sw), .rdata(rdata0), .irq(irq0)
    );

    switch_ctrl #(
        .WIDTH(8), .BASE_ADDR(c_base), .TICK_DIV(4), .DEB_SAMPLES(3), .EDGE_MODE(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .addr(addr), .rd_en(rd_en), .wr_en(wr_en),
        .wdata(wdata), .sw(sw), .rdata(rdata2), .irq(irq2)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a,
                            input logic [31:0] e0, input logic [31:0] e2);
        string t;
        q_tag.push_back(tag);
        q_exp0.push_back(e0);
        q_exp2.push_back(e2);
        addr  = a;
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        t = q_tag.pop_front();
        check({t, "/m0"}, rdata0, q_exp0.pop_front());
        check({t, "/m2"}, rdata2, q_exp2.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic glitch_seen;
        logic irq_at, irq_pre, last_irq;
        int   lat;
        int   start;
        int   edge_lat;

        // Reset with all switches high
        sw    = 8'hFF;
        rst_n = 1'b0;
        step(5);
        check("rst_rdata/m0", rdata0, 32'h0);
        check("rst_rdata/m2", rdata2, 32'h0);
        check("rst_irq/m0", {31'h0, irq0}, 32'h0);
        check("rst_irq/m2", {31'h0, irq2}, 32'h0);
        rst_n = 1'b1;
        sw    = 8'h00;
        bus_read("data_after_rst", c_base, 32'h0, 32'h0);
        bus_read("edge_after_rst", c_base + 32'h8, 32'h0, 32'h0);

        // Debounce latency on sw[0]
        sw[0] = 1'b1;
        addr  = c_base;
        rd_en = 1'b1;
        found = 1'b0;
        lat   = 0;
        for (int k = 1; k <= 20 && !found; k++) begin
            step();
            if (rdata0[0]) begin
                found = 1'b1;
                lat   = k;
            end
        end
        check("deb_found", {31'h0, found}, 32'h1);
        check("deb_latency_in_range", {31'h0, (lat >= 12 && lat <= 15)}, 32'h1);

        // One-tick glitch on sw[1] must never reach DATA
        glitch_seen = 1'b0;
        sw[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            glitch_seen = glitch_seen | rdata0[1] | rdata2[1];
        end
        sw[1] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            glitch_seen = glitch_seen | rdata0[1] | rdata2[1];
        end
        rd_en = 1'b0;
        check("glitch_filtered", {31'h0, glitch_seen}, 32'h0);
        bus_read("data_after_deb", c_base, 32'h1, 32'h1);

        bus_write(c_base + 32'h8, 32'hFF);
        bus_read("edge_cleared", c_base + 32'h8, 32'h0, 32'h0);

        // Edge capture and interrupt
        bus_write(c_base + 32'hC, 32'h1);
        sw[0] = 1'b0;
        step(20);
        bus_read("edge_fall", c_base + 32'h8, 32'h0, 32'h1);
        check("irq_fall/m0", {31'h0, irq0}, 32'h0);
        check("irq_fall/m2", {31'h0, irq2}, 32'h1);
        bus_write(c_base + 32'h8, 32'h1);
        step();
        check("irq_idle/m0", {31'h0, irq0}, 32'h0);
        check("irq_idle/m2", {31'h0, irq2}, 32'h0);

        sw[0]    = 1'b1;
        addr     = c_base + 32'h8;
        rd_en    = 1'b1;
        found    = 1'b0;
        irq_at   = 1'b0;
        irq_pre  = 1'b1;
        last_irq = irq0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (rdata0[0]) begin
                found   = 1'b1;
                irq_at  = irq0;
                irq_pre = last_irq;
            end
            last_irq = irq0;
        end
        rd_en = 1'b0;
        check("rise_edge_seen", {31'h0, found}, 32'h1);
        check("irq_with_edge", {31'h0, irq_at}, 32'h1);
        check("irq_before_edge", {31'h0, irq_pre}, 32'h0);
        bus_read("edge_rise", c_base + 32'h8, 32'h1, 32'h1);

        sw[0] = 1'b0;
        step(20);
        bus_read("edge_sticky", c_base + 32'h8, 32'h1, 32'h1);
        bus_write(c_base + 32'h8, 32'h1);
        check("irq_lag_w1c", {31'h0, irq0}, 32'h1);
        step();
        check("irq_clr/m0", {31'h0, irq0}, 32'h0);
        check("irq_clr/m2", {31'h0, irq2}, 32'h0);
        bus_read("edge_w1c", c_base + 32'h8, 32'h0, 32'h0);

        // Measure sw-to-edge latency at a fixed prescaler phase
        addr  = c_base + 32'h8;
        rd_en = 1'b1;
        while (cyc % 4 != 0) step();
        start    = cyc;
        sw[2]    = 1'b1;
        found    = 1'b0;
        edge_lat = 8;
        for (int k = 0; k < 24 && !found; k++) begin
            step();
            if (rdata2[2]) begin
                found    = 1'b1;
                edge_lat = cyc - start;
            end
        end
        rd_en = 1'b0;
        check("coll_probe_seen", {31'h0, found}, 32'h1);
        step(20);
        bus_write(c_base + 32'h8, 32'h4);
        step(2);

        // Same-cycle set and W1C clear on bit 2
        while (cyc % 4 != 0) step();
        sw[2] = 1'b0;
        step(edge_lat - 2);
        addr  = c_base + 32'h8;
        wdata = 32'h4;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        step(20);
        bus_read("edge_collision", c_base + 32'h8, 32'h0, 32'h4);

        // Bus behaviour
        sw = 8'hA5;
        step(20);
        bus_read("raw", c_base + 32'h4, 32'hA5, 32'hA5);
        bus_read("unmapped_holds", c_base + 32'h10, 32'hA5, 32'hA5);
        bus_write(c_base, 32'hFF);
        bus_write(c_base + 32'h4, 32'h00);
        bus_read("data_read_only", c_base, 32'hA5, 32'hA5);
        bus_write(c_base + 32'hC, 32'hFFFF_FF02);
        bus_write(c_base + 32'h10, 32'hFF);
        bus_read("irq_en_width", c_base + 32'hC, 32'h2, 32'h2);

        // Mid-operation reset
        sw = 8'h00;
        step(20);
        bus_write(c_base + 32'h8, 32'hFF);
        sw = 8'hFF;
        step(20);
        bus_write(c_base + 32'hC, 32'hFF);
        step();
        check("pre_rst_irq/m0", {31'h0, irq0}, 32'h1);
        check("pre_rst_irq/m2", {31'h0, irq2}, 32'h1);
        bus_read("pre_rst_edge", c_base + 32'h8, 32'hFF, 32'hFF);
        rst_n = 1'b0;
        step();
        check("mid_rst_rdata/m0", rdata0, 32'h0);
        check("mid_rst_rdata/m2", rdata2, 32'h0);
        check("mid_rst_irq/m0", {31'h0, irq0}, 32'h0);
        check("mid_rst_irq/m2", {31'h0, irq2}, 32'h0);
        rst_n = 1'b1;
        bus_read("post_rst_data", c_base, 32'h0, 32'h0);
        bus_read("post_rst_edge", c_base + 32'h8, 32'h0, 32'h0);
        bus_read("post_rst_irqen", c_base + 32'hC, 32'h0, 32'h0);
        bus_read("post_rst_data_hold", c_base, 32'h0, 32'h0);
        step(20);
        bus_read("post_rst_data_deb", c_base, 32'hFF, 32'hFF);
        bus_read("post_rst_edge_new", c_base + 32'h8, 32'hFF, 32'hFF);
        check("post_rst_irq/m0", {31'h0, irq0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
